tx_word_serializer: RTL
=======================

TX_WORD_SERIALIZER -- requirements
Module: tx_word_serializer

Interface
REQ-001 SHALL have parameter NBITS, default 32, width of word from debug controller; must be a multiple of 8.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, width of byte to UART transmitter.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tx_Data  input  NBITS  word to transmit, from debug controller.
REQ-006 SHALL have port tx_start  input  1  request to transmit tx_Data, from debug controller.
REQ-007 SHALL have port tx_done  output  1  one-cycle pulse: whole word sent, to debug controller.
REQ-008 SHALL have port byte_data  output  BYTE_WIDTH  current byte, to UART transmitter.
REQ-009 SHALL have port byte_start  output  1  one-cycle pulse: start sending byte_data.
REQ-010 SHALL have port byte_done  input  1  pulse from UART transmitter: current byte finished.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM with states IDLE, START, WAIT, DONE; NBYTES = NBITS/BYTE_WIDTH; byte index counter 0..NBYTES-1.
REQ-013 IDLE: on tx_start=1, SHALL latch tx_Data into internal shift register, clear index, go to START.
REQ-014 START: SHALL drive byte_start=1 for exactly one cycle, then go to WAIT.
REQ-015 WAIT: SHALL hold byte_start=0 until byte_done=1; then if index=NBYTES-1 go to DONE, else increment index and go to START.
REQ-016 DONE: SHALL drive tx_done=1 for exactly one cycle, then go to IDLE.
REQ-017 byte_data SHALL be stable from the START cycle through the cycle byte_done is sampled; it SHALL change only on the START entry that follows.
REQ-018 Latency: tx_start sampled at edge N -> byte_start high in cycle N+1; last byte_done sampled at edge M -> tx_done high in cycle M+1.
REQ-019 tx_start while busy=1 SHALL be ignored; tx_Data changes while busy SHALL NOT affect the word in flight.
REQ-020 byte_done in IDLE, START or DONE SHALL be ignored; byte_done on the same edge as entry into WAIT SHALL be sampled on the next edge only.
REQ-021 tx_start in the DONE cycle SHALL be ignored; a new word may be accepted from the first IDLE cycle onward (minimum 2*NBYTES+2 cycles per word).
REQ-022 tx_done and byte_start SHALL never be high in the same cycle.

Reset
REQ-023 reset=1 SHALL immediately force state IDLE, index 0, shift register 0, byte_data 0, byte_start 0, tx_done 0, busy 0, independent of clk.
REQ-024 reset asserted mid-word SHALL abort the word with no tx_done pulse; the first tx_start after release SHALL be serviced normally.

Configuration
REQ-025 Macro TX_MSB_FIRST_EN defined: bytes SHALL be sent most-significant first (tx_Data[NBITS-1:NBITS-8] first).
REQ-026 Macro TX_MSB_FIRST_EN undefined: bytes SHALL be sent least-significant first (tx_Data[7:0] first); FSM timing identical in both builds.

Verification
REQ-027 Macro undefined, tx_Data=0x11223344, tx_start pulse, byte_done 3 cycles after each byte_start -> byte_data sequence 0x44,0x33,0x22,0x11; exactly 4 byte_start pulses; one tx_done pulse one cycle after the 4th byte_done.
REQ-028 Macro defined, same stimulus -> byte_data sequence 0x11,0x22,0x33,0x44; same pulse counts and timing.
REQ-029 tx_start pulsed again with tx_Data=0xFFFFFFFF while sending 0x00000045 -> only 0x45,0x00,0x00,0x00 sent (LSB build); one tx_done; busy stays high until DONE.
REQ-030 byte_done pulsed in IDLE, then immediate byte_done on the cycle START->WAIT -> no index advance in IDLE; byte 0 completes on the next sampled byte_done only.
REQ-031 reset asserted during WAIT of byte 2 -> all outputs 0 asynchronously, no tx_done; next word 0x00000002 sent completely as 0x02,0x00,0x00,0x00.
REQ-032 Back-to-back words 0x00000003 then 0x00000FFF, tx_start asserted first IDLE cycle after tx_done -> 8 bytes in order, two tx_done pulses, no dropped or repeated byte.

Source files
------------

// File: rtl/tx_word_serializer.sv
// rtl/tx_word_serializer.sv - splits a debug-controller word into bytes for a UART transmitter
// Build option: define TX_MSB_FIRST_EN to send the most-significant byte first
//               (default build sends the least-significant byte first).

module tx_word_serializer #(
  parameter int NBITS      = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NBITS-1:0]      tx_Data,
  input  logic                  tx_start,
  output logic                  tx_done,
  output logic [BYTE_WIDTH-1:0] byte_data,
  output logic                  byte_start,
  input  logic                  byte_done,
  output logic                  busy
);

  localparam int NBYTES = NBITS / BYTE_WIDTH;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_index;
  logic [NBITS-1:0]      r_shift;
  logic [BYTE_WIDTH-1:0] r_byte_data;
  logic                  r_byte_start;
  logic                  r_tx_done;
  logic                  r_busy;

  // The byte presented next is always taken from one fixed end of the shift
  // register; the build option only decides which end and the shift direction.
  logic [BYTE_WIDTH-1:0] w_first_byte;
  logic [NBITS-1:0]      w_shift_next;
  logic [BYTE_WIDTH-1:0] w_next_byte;

`ifdef TX_MSB_FIRST_EN
  assign w_first_byte = tx_Data[NBITS-1 -: BYTE_WIDTH];
  assign w_shift_next = r_shift << BYTE_WIDTH;
  assign w_next_byte  = w_shift_next[NBITS-1 -: BYTE_WIDTH];
`else
  assign w_first_byte = tx_Data[BYTE_WIDTH-1:0];
  assign w_shift_next = r_shift >> BYTE_WIDTH;
  assign w_next_byte  = w_shift_next[BYTE_WIDTH-1:0];
`endif

  // Serializer FSM; every output is registered and only moves on state entry,
  // so byte_data is held from START through the byte_done sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_index      <= '0;
      r_shift      <= '0;
      r_byte_data  <= '0;
      r_byte_start <= 1'b0;
      r_tx_done    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_byte_start <= 1'b0;
      r_tx_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            r_shift      <= tx_Data;
            r_index      <= '0;
            r_byte_data  <= w_first_byte;
            r_byte_start <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_START;
          end
        end
        S_START: begin
          // byte_done on this edge belongs to no byte yet and is dropped
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (byte_done) begin
            if (r_index == LAST_IDX) begin
              r_tx_done <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_index      <= r_index + IDX_W'(1);
              r_shift      <= w_shift_next;
              r_byte_data  <= w_next_byte;
              r_byte_start <= 1'b1;
              r_state      <= S_START;
            end
          end
        end
        S_DONE: begin
          // tx_start seen here is ignored; the next word is taken from IDLE
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_done    = r_tx_done;
  assign byte_data  = r_byte_data;
  assign byte_start = r_byte_start;
  assign busy       = r_busy;

endmodule
